// File: rtl/parallax_layer_engine_if.sv
// Pixel-timing strobes from the sync generator and the per-pixel layer
// result returned to the palette/dither stage.
interface parallax_layer_engine_if #(
    parameter int N_LAYERS = 4
);
    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic               pix_en;
    logic               line_end;
    logic               frame_end;
    logic [9:0]         vcount;
    logic               scroll_en;
    logic               hit;
    logic [LAYER_W-1:0] layer;
    logic               border;

    modport master (
        output pix_en, line_end, frame_end, vcount, scroll_en,
        input  hit, layer, border
    );

    modport slave (
        input  pix_en, line_end, frame_end, vcount, scroll_en,
        output hit, layer, border
    );
endinterface

// File: rtl/parallax_layer_engine.sv
// Scrolling skyline generator: N_LAYERS LFSR-driven column profiles, each with its
// own vertical band scheduler, resolved front-to-back into one registered pixel result.
//
// Vertical scheduler (per layer)
//   state    | meaning
//   ST_IDLE  | band not reached yet this frame, cutoff = 0
//   ST_RUN   | inside the band, cutoff grows one step every 2^ROW_LOG2 lines
//   ST_SAT   | cutoff pinned at 2^HEIGHT_BITS, every column covered
module parallax_layer_engine #(
    parameter int                         N_LAYERS    = 4,
    parameter int                         LFSR_W      = 10,
    parameter logic [LFSR_W-1:0]          LFSR_TAPS   = 10'h240,
    parameter int                         HEIGHT_BITS = 4,
    parameter logic [N_LAYERS*LFSR_W-1:0] SEEDS       = {N_LAYERS{10'h3FF}},
    parameter logic [N_LAYERS*10-1:0]     START_ROW   = {10'd400, 10'd300, 10'd200, 10'd100},
    parameter logic [N_LAYERS*3-1:0]      ROW_LOG2    = {3'd2, 3'd3, 3'd3, 3'd4},
    parameter logic [N_LAYERS*3-1:0]      COL_LOG2    = {3'd5, 3'd4, 3'd3, 3'd3},
    parameter logic [N_LAYERS*3-1:0]      SCROLL_LOG2 = {3'd3, 3'd2, 3'd1, 3'd1},
    parameter int                         BORDER_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    parallax_layer_engine_if.slave          px
);

    localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam logic [HEIGHT_BITS:0] CUT_SAT = (HEIGHT_BITS + 1)'(1 << HEIGHT_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } sched_t;

    // One column advance: HEIGHT_BITS LFSR shifts collapsed into a single cycle.
    function automatic logic [LFSR_W-1:0] col_adv(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] r;
        r = v;
        for (int k = 0; k < HEIGHT_BITS; k++) begin
            r = {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
        end
        return r;
    endfunction

    logic [N_LAYERS-1:0] cov_w;
    logic [N_LAYERS-1:0] edge_w;

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
        localparam int C = int'(COL_LOG2[g*3 +: 3]);
        localparam int S = int'(SCROLL_LOG2[g*3 +: 3]);
        localparam int R = int'(ROW_LOG2[g*3 +: 3]);
        localparam logic [7:0] CMASK = 8'((1 << C) - 1);
        localparam logic [7:0] SMASK = 8'((1 << S) - 1);
        localparam logic [7:0] RMASK = 8'((1 << R) - 1);
        localparam logic [LFSR_W-1:0] SEED = SEEDS[g*LFSR_W +: LFSR_W];
        localparam logic [9:0] SROW = START_ROW[g*10 +: 10];

        logic [LFSR_W-1:0]    lfsr_q, lfsr_d, lfsr_b_q, lfsr_b_d;
        logic [7:0]           phase_q, phase_d, phase_b_q, phase_b_d;
        logic [7:0]           fdiv_q, fdiv_d;
        logic [7:0]           rowcnt_q;
        logic [HEIGHT_BITS:0] cutoff_q;
        sched_t               state_q;
        logic                 vborder, hborder;

        // Frame-rate scroll chain: fdiv -> phase_b -> lfsr_b.
        always_comb begin
            fdiv_d    = fdiv_q;
            phase_b_d = phase_b_q;
            lfsr_b_d  = lfsr_b_q;
            if (px.frame_end && px.scroll_en) begin
                fdiv_d = (fdiv_q + 8'd1) & SMASK;
                if (fdiv_d == 8'd0) begin
                    phase_b_d = (phase_b_q + 8'd1) & CMASK;
                    if (phase_b_d == 8'd0) begin
                        lfsr_b_d = col_adv(lfsr_b_q);
                    end
                end
            end
        end

        // The line reload takes the post-scroll base so a new frame starts on fresh state.
        always_comb begin
            lfsr_d  = lfsr_q;
            phase_d = phase_q;
            if (px.line_end) begin
                lfsr_d  = lfsr_b_d;
                phase_d = phase_b_d;
            end else if (px.pix_en) begin
                phase_d = (phase_q + 8'd1) & CMASK;
                if (phase_q == CMASK) begin
                    lfsr_d = col_adv(lfsr_q);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lfsr_q    <= SEED;
                lfsr_b_q  <= SEED;
                phase_q   <= 8'd0;
                phase_b_q <= 8'd0;
                fdiv_q    <= 8'd0;
            end else begin
                lfsr_q    <= lfsr_d;
                lfsr_b_q  <= lfsr_b_d;
                phase_q   <= phase_d;
                phase_b_q <= phase_b_d;
                fdiv_q    <= fdiv_d;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                rowcnt_q <= 8'd0;
                cutoff_q <= '0;
            end else if (px.frame_end) begin
                state_q  <= ST_IDLE;
                rowcnt_q <= 8'd0;
                cutoff_q <= '0;
            end else if (px.line_end) begin
                case (state_q)
                    ST_IDLE: begin
                        if (px.vcount == SROW) begin
                            state_q  <= ST_RUN;
                            rowcnt_q <= 8'd0;
                            cutoff_q <= (HEIGHT_BITS + 1)'(1);
                        end
                    end
                    ST_RUN: begin
                        rowcnt_q <= (rowcnt_q + 8'd1) & RMASK;
                        if (rowcnt_q == RMASK) begin
                            cutoff_q <= cutoff_q + 1'b1;
                            if (cutoff_q == CUT_SAT - 1'b1) begin
                                state_q <= ST_SAT;
                            end
                        end
                    end
                    ST_SAT: begin
                        cutoff_q <= CUT_SAT;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        cutoff_q <= '0;
                    end
                endcase
            end
        end

        assign vborder   = (state_q == ST_RUN) && ((rowcnt_q == 8'd0) || (rowcnt_q == RMASK));
        assign hborder   = phase_q < 8'(BORDER_W);
        assign cov_w[g]  = {1'b0, lfsr_q[HEIGHT_BITS-1:0]} < cutoff_q;
        assign edge_w[g] = vborder | hborder;
    end

    logic               hit_q, hit_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               border_q, border_d;

    // Walk back to front so the frontmost covering layer is the one left standing.
    always_comb begin
        hit_d    = 1'b0;
        layer_d  = '0;
        border_d = 1'b0;
        if (px.pix_en) begin
            for (int i = N_LAYERS - 1; i >= 0; i--) begin
                if (cov_w[i]) begin
                    hit_d    = 1'b1;
                    layer_d  = LAYER_W'(i);
                    border_d = edge_w[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q    <= 1'b0;
            layer_q  <= '0;
            border_q <= 1'b0;
        end else begin
            hit_q    <= hit_d;
            layer_q  <= layer_d;
            border_q <= border_d;
        end
    end

    assign px.hit    = hit_q;
    assign px.layer  = layer_q;
    assign px.border = border_q;

endmodule

// File: tb/tb_parallax_layer_engine.sv
// Randomized frame stimulus checked against a scroll-offset/line-count model of the skyline.
module tb_parallax_layer_engine;

    localparam int N      = 4;
    localparam int HB     = 4;
    localparam int BW     = 2;
    localparam int NLINES = 40;
    localparam int PIXW   = 24;
    localparam logic [9:0]    TAPS      = 10'h240;
    localparam logic [N*10-1:0] SEEDS   = {10'h3FF, 10'h0F1, 10'h2C3, 10'h1A5};
    localparam logic [N*10-1:0] SROWS   = {10'd12, 10'd8, 10'd3, 10'd5};
    localparam logic [N*3-1:0]  ROWL    = {3'd1, 3'd2, 3'd0, 3'd1};
    localparam logic [N*3-1:0]  COLL    = {3'd0, 3'd1, 3'd2, 3'd3};
    localparam logic [N*3-1:0]  SCRL    = {3'd0, 3'd2, 3'd0, 3'd1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parallax_layer_engine_if #(.N_LAYERS(N)) px();

    parallax_layer_engine #(
        .N_LAYERS(N), .LFSR_W(10), .LFSR_TAPS(TAPS), .HEIGHT_BITS(HB),
        .SEEDS(SEEDS), .START_ROW(SROWS), .ROW_LOG2(ROWL), .COL_LOG2(COLL),
        .SCROLL_LOG2(SCRL), .BORDER_W(BW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .px(px)
    );

    int tests = 0;
    int fails = 0;

    // Model: image at pixel x of a line is a function of the scroll offset and x;
    // the band is a function of how many lines have passed since the start row.
    int heights [N][128];
    int frames_sc;
    int off_line [N];
    int xcnt;
    bit started [N];
    int lrow [N];

    function automatic logic [9:0] ref_col_adv(input logic [9:0] v);
        logic [9:0] r;
        r = v;
        for (int k = 0; k < HB; k++) r = {r[8:0], ^(r & TAPS)};
        return r;
    endfunction

    task automatic model_reset();
        frames_sc = 0;
        xcnt = 0;
        for (int i = 0; i < N; i++) begin
            off_line[i] = 0;
            started[i] = 0;
            lrow[i] = 0;
        end
    endtask

    function automatic logic [3:0] expect_out(input bit pe);
        int c, r, pos, ph, h, cut, steps, rc;
        bit run, vb, hb;
        if (!pe) return 4'd0;
        for (int i = 0; i < N; i++) begin
            c     = int'(COLL[i*3 +: 3]);
            r     = int'(ROWL[i*3 +: 3]);
            pos   = off_line[i] + xcnt;
            ph    = pos % (1 << c);
            h     = heights[i][pos >> c];
            steps = started[i] ? 1 + (lrow[i] >> r) : 0;
            cut   = (steps > 16) ? 16 : steps;
            run   = started[i] && (steps < 16);
            rc    = lrow[i] % (1 << r);
            vb    = run && (rc == 0 || rc == (1 << r) - 1);
            hb    = ph < BW;
            if (h < cut) return {1'b1, 2'(i), vb | hb};
        end
        return 4'd0;
    endfunction

    task automatic model_update(input bit pe, input bit le, input bit fe, input int vc, input bit se);
        if (fe && se) frames_sc++;
        if (le) begin
            xcnt = 0;
            for (int i = 0; i < N; i++) begin
                off_line[i] = frames_sc >> int'(SCRL[i*3 +: 3]);
                if (fe) started[i] = 0;
                else if (started[i]) lrow[i]++;
                else if (vc == int'(SROWS[i*10 +: 10])) begin
                    started[i] = 1;
                    lrow[i] = 0;
                end
            end
        end else if (pe) begin
            xcnt++;
        end
    endtask

    task automatic step(input bit pe, input bit le, input bit fe, input int vc, input bit se, input string tag);
        logic [3:0] exp_v, got;
        px.pix_en    = pe;
        px.line_end  = le;
        px.frame_end = fe;
        px.vcount    = 10'(vc);
        px.scroll_en = se;
        exp_v = expect_out(pe);
        model_update(pe, le, fe, vc, se);
        @(posedge clk);
        @(negedge clk);
        got = {px.hit, px.layer, px.border};
        tests++;
        assert (got === exp_v) else begin
            fails++;
            $error("FAIL %s line %0d: observed {hit,layer,border}=%b expected %b", tag, vc, got, exp_v);
        end
    endtask

    task automatic run_frame(input bit se, input int abort_line, output bit aborted);
        bit coinc, last;
        aborted = 0;
        for (int v = 0; v < NLINES; v++) begin
            coinc = ($urandom_range(0, 5) == 0);
            last  = (v == NLINES - 1);
            for (int x = 0; x < PIXW; x++) begin
                if (v == abort_line && x == 8) begin
                    aborted = 1;
                    return;
                end
                if (coinc && x == PIXW - 1) step(1'b1, 1'b1, last, v, se, "coincident");
                else step($urandom_range(0, 15) != 0, 1'b0, 1'b0, v, se, "pixel");
            end
            step(1'b0, 1'b0, 1'b0, v, se, "blank");
            step(1'b0, 1'b0, 1'b0, v, se, "blank");
            if (!coinc) step(1'b0, 1'b1, last, v, se, "line_end");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] v;
        logic [3:0] exp_v, got;
        bit ab;

        for (int i = 0; i < N; i++) begin
            v = SEEDS[i*10 +: 10];
            for (int k = 0; k < 128; k++) begin
                heights[i][k] = int'(v[HB-1:0]);
                v = ref_col_adv(v);
            end
        end

        px.pix_en = 0; px.line_end = 0; px.frame_end = 0; px.vcount = '0; px.scroll_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        got = {px.hit, px.layer, px.border};
        tests++;
        assert (got === 4'd0) else begin
            fails++;
            $error("FAIL reset_state: observed %b expected %b", got, 4'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        repeat (3) run_frame(1'b1, -1, ab);
        repeat (5) run_frame(1'b0, -1, ab);
        repeat (20) run_frame($urandom_range(0, 3) != 0, -1, ab);

        // Layer 0 is saturated on line 38, so the pixel before reset must be covered.
        run_frame(1'b1, 38, ab);
        px.pix_en = 1; px.line_end = 0; px.frame_end = 0;
        exp_v = expect_out(1'b1);
        @(posedge clk);
        #1;
        got = {px.hit, px.layer, px.border};
        tests++;
        assert (got === exp_v) else begin
            fails++;
            $error("FAIL pre_reset_pixel: observed %b expected %b", got, exp_v);
        end
        #1 rst_n = 1'b0;
        #1;
        got = {px.hit, px.layer, px.border};
        tests++;
        assert (got === 4'd0) else begin
            fails++;
            $error("FAIL async_reset: observed %b expected %b", got, 4'd0);
        end
        px.pix_en = 0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        repeat (5) run_frame($urandom_range(0, 3) != 0, -1, ab);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
